// File: rtl/vend_pkg.sv
// Shared definitions for the multi-product vending controller: coin codes,
// FSM state encodings and the coin code -> nickel value helper.
package vend_pkg;

   localparam logic [2:0] COIN_NONE        = 3'd0;
   localparam logic [2:0] COIN_NICKEL      = 3'd1;
   localparam logic [2:0] COIN_DIME        = 3'd2;
   localparam logic [2:0] COIN_NICKEL_DIME = 3'd3;
   localparam logic [2:0] COIN_DIME_DIME   = 3'd4;
   localparam logic [2:0] COIN_QUARTER     = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CREDIT = 2'd1,
      ST_VEND   = 2'd2,
      ST_CHANGE = 2'd3
   } state_t;

   // Returns {legal, value[2:0]}; value is in nickels. "No coin" is not legal.
   function automatic logic [3:0] coin_value(input logic [2:0] code);
      case (code)
         COIN_NICKEL:      return {1'b1, 3'd1};
         COIN_DIME:        return {1'b1, 3'd2};
         COIN_NICKEL_DIME: return {1'b1, 3'd3};
         COIN_DIME_DIME:   return {1'b1, 3'd4};
         COIN_QUARTER:     return {1'b1, 3'd5};
         default:          return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/vend_coin_decode.sv
// Combinational coin decoder, shared with the coin acceptor front end.
module vend_coin_decode
   import vend_pkg::*;
(
   input  logic [2:0] coin,
   output logic       legal,
   output logic [2:0] value
);

   // Split the packed {legal, value} result into its two fields.
   always_comb begin
      {legal, value} = coin_value(coin);
   end

endmodule

// File: rtl/vend_multi_ctrl.sv
// Multi-product vending controller.
//
// state  | meaning
// IDLE   | no credit held, waiting for a coin
// CREDIT | credit held, accepting coins, selection or cancel
// VEND   | one-cycle dispense pulse, change amount already latched
// CHANGE | presenting change_amt to the hopper until change_ready
module vend_multi_ctrl
   import vend_pkg::*;
#(
   parameter int NUM_PRODUCTS = 4,
   parameter int CREDIT_W     = 6,
   parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICES = {6'd7, 6'd3, 6'd4, 6'd5},
   parameter int MAX_CREDIT   = 20,
   localparam int SEL_W = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
)
(
   input  logic                clock,
   input  logic                reset,
   input  logic [2:0]          coin,
   input  logic                sel_valid,
   input  logic [SEL_W-1:0]    sel,
   input  logic                cancel,
   input  logic                change_ready,
   output logic                vend,
   output logic [SEL_W-1:0]    vend_id,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amt,
   output logic                coin_reject,
   output logic                sel_err,
   output logic [CREDIT_W-1:0] credit,
   output logic [1:0]          state
);

   localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [SEL_W:0]    NUM_P = (SEL_W+1)'(NUM_PRODUCTS);

   state_t              state_q;
   logic                coin_legal;
   logic [2:0]          coin_val;
   logic [CREDIT_W:0]   credit_sum;
   logic                coin_ok;
   logic                coin_present;
   logic [CREDIT_W-1:0] price_sel;
   logic                sel_ok;

   assign state = state_q;

   vend_coin_decode u_coin_decode (
      .coin  (coin),
      .legal (coin_legal),
      .value (coin_val)
   );

   // Price lookup for the requested product; out-of-range selections read 0
   // but are refused by the range check below.
   always_comb begin
      price_sel = '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         if (sel == SEL_W'(i)) price_sel = PRICES[i*CREDIT_W +: CREDIT_W];
      end
   end

   // Ceiling check one bit wider than credit so the sum cannot wrap.
   always_comb begin
      coin_present = (coin != COIN_NONE);
      credit_sum   = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
      coin_ok      = coin_legal && (credit_sum <= MAX_C);
      sel_ok       = ({1'b0, sel} < NUM_P) && (credit >= price_sel);
   end

   // Controller FSM with all outputs registered.
   always_ff @(posedge clock) begin
      vend        <= 1'b0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
      if (reset) begin
         state_q      <= ST_IDLE;
         credit       <= '0;
         vend_id      <= '0;
         change_valid <= 1'b0;
         change_amt   <= '0;
      end else begin
         case (state_q)
            ST_IDLE, ST_CREDIT: begin
               if (cancel) begin
                  coin_reject <= coin_present;
                  if (state_q == ST_CREDIT) begin
                     change_amt   <= credit;
                     change_valid <= 1'b1;
                     credit       <= '0;
                     state_q      <= ST_CHANGE;
                  end
               end else if (sel_valid) begin
                  coin_reject <= coin_present;
                  if (state_q == ST_IDLE || !sel_ok) begin
                     sel_err <= 1'b1;
                  end else begin
                     vend       <= 1'b1;
                     vend_id    <= sel;
                     change_amt <= credit - price_sel;
                     credit     <= '0;
                     state_q    <= ST_VEND;
                  end
               end else if (coin_present) begin
                  if (coin_ok) begin
                     credit  <= credit_sum[CREDIT_W-1:0];
                     state_q <= ST_CREDIT;
                  end else begin
                     coin_reject <= 1'b1;
                  end
               end
            end
            ST_VEND: begin
               coin_reject <= coin_present;
               if (change_amt == '0) begin
                  state_q <= ST_IDLE;
               end else begin
                  change_valid <= 1'b1;
                  state_q      <= ST_CHANGE;
               end
            end
            ST_CHANGE: begin
               coin_reject <= coin_present;
               if (change_ready) begin
                  change_valid <= 1'b0;
                  change_amt   <= '0;
                  state_q      <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_multi_ctrl.sv
// Self-checking bench for vend_multi_ctrl: directed scenarios followed by
// random traffic, every cycle compared against a behavioural model.
module tb_vend_multi_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] coin = 3'd0;
   logic       sel_valid = 1'b0;
   logic [1:0] sel = 2'd0;
   logic       cancel = 1'b0;
   logic       change_ready = 1'b0;
   logic       vend;
   logic [1:0] vend_id;
   logic       change_valid;
   logic [5:0] change_amt;
   logic       coin_reject;
   logic       sel_err;
   logic [5:0] credit;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   // Reference model: product prices in nickels (25c, 20c, 15c, 35c).
   int prices [4] = '{5, 4, 3, 7};
   int max_credit = 20;
   int m_st, m_credit, m_chg, m_vid;
   int e_vend, e_cv, e_rej, e_serr;

   vend_multi_ctrl dut (
      .clock        (clock),
      .reset        (reset),
      .coin         (coin),
      .sel_valid    (sel_valid),
      .sel          (sel),
      .cancel       (cancel),
      .change_ready (change_ready),
      .vend         (vend),
      .vend_id      (vend_id),
      .change_valid (change_valid),
      .change_amt   (change_amt),
      .coin_reject  (coin_reject),
      .sel_err      (sel_err),
      .credit       (credit),
      .state        (state)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Model of one clock edge: phase 0 idle, 1 holding credit, 2 dispensing, 3 paying change.
   task automatic model(input int c, input int sv, input int s, input int cn,
                        input int rdy, input int rst);
      int v;
      e_vend = 0; e_rej = 0; e_serr = 0;
      if (rst != 0) begin
         m_st = 0; m_credit = 0; m_chg = 0; m_vid = 0; e_cv = 0;
      end else if (m_st == 2) begin
         e_rej = (c != 0);
         if (m_chg == 0) m_st = 0;
         else begin m_st = 3; e_cv = 1; end
      end else if (m_st == 3) begin
         e_rej = (c != 0);
         if (rdy != 0) begin m_st = 0; e_cv = 0; m_chg = 0; end
      end else if (cn != 0) begin
         e_rej = (c != 0);
         if (m_st == 1) begin
            m_chg = m_credit; m_credit = 0; m_st = 3; e_cv = 1;
         end
      end else if (sv != 0) begin
         e_rej = (c != 0);
         if (m_st == 0 || s >= 4 || m_credit < prices[s]) e_serr = 1;
         else begin
            m_vid = s; m_chg = m_credit - prices[s]; m_credit = 0; m_st = 2; e_vend = 1;
         end
      end else if (c != 0) begin
         v = (c <= 5) ? c : 0;
         if (c > 5 || m_credit + v > max_credit) e_rej = 1;
         else begin m_credit = m_credit + v; m_st = 1; end
      end
   endtask

   task automatic check_all();
      chk("state", 32'(state), 32'(m_st));
      chk("credit", 32'(credit), 32'(m_credit));
      chk("vend", 32'(vend), 32'(e_vend));
      chk("vend_id", 32'(vend_id), 32'(m_vid));
      chk("change_valid", 32'(change_valid), 32'(e_cv));
      chk("change_amt", 32'(change_amt), 32'(m_chg));
      chk("coin_reject", 32'(coin_reject), 32'(e_rej));
      chk("sel_err", 32'(sel_err), 32'(e_serr));
   endtask

   task automatic step(input int c, input int sv, input int s, input int cn,
                       input int rdy, input int rst);
      @(negedge clock);
      coin = 3'(c); sel_valid = 1'(sv); sel = 2'(s); cancel = 1'(cn);
      change_ready = 1'(rdy); reset = 1'(rst);
      model(c, sv, s, cn, rdy, rst);
      @(posedge clock);
      #1;
      check_all();
   endtask

   initial begin
      int c, sv, cn, rdy, rst;
      m_st = 0; m_credit = 0; m_chg = 0; m_vid = 0;
      e_vend = 0; e_cv = 0; e_rej = 0; e_serr = 0;

      // Reset state
      step(0, 0, 0, 0, 0, 1);
      chk("reset_state", 32'(state), 32'd0);

      // Quarter then product 0, exact payment
      step(5, 0, 0, 0, 0, 0);
      chk("quarter_credit", 32'(credit), 32'd5);
      step(0, 1, 0, 0, 0, 0);
      chk("exact_vend", 32'(vend), 32'd1);
      step(0, 0, 0, 0, 0, 0);
      chk("exact_no_change", 32'(change_valid), 32'd0);
      chk("exact_idle", 32'(state), 32'd0);

      // 8 nickels, product 2 costs 3, change 5 held under backpressure
      step(1, 0, 0, 0, 0, 0);
      step(2, 0, 0, 0, 0, 0);
      step(5, 0, 0, 0, 0, 0);
      chk("credit8", 32'(credit), 32'd8);
      step(0, 1, 2, 0, 0, 0);
      chk("vend_id2", 32'(vend_id), 32'd2);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
      chk("change_held", 32'(change_amt), 32'd5);
      step(0, 0, 0, 0, 1, 0);
      chk("handshake_idle", 32'(state), 32'd0);

      // Insufficient credit then cancel refund
      step(2, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("sel_err_pulse", 32'(sel_err), 32'd1);
      chk("credit_kept", 32'(credit), 32'd2);
      step(0, 0, 0, 1, 0, 0);
      chk("refund_amt", 32'(change_amt), 32'd2);
      step(0, 0, 0, 0, 1, 0);

      // Credit ceiling, illegal code, then vend product 3 with change 13
      for (int i = 0; i < 4; i++) step(5, 0, 0, 0, 0, 0);
      chk("credit_max", 32'(credit), 32'd20);
      step(5, 0, 0, 0, 0, 0);
      chk("ceiling_reject", 32'(coin_reject), 32'd1);
      step(6, 0, 0, 0, 0, 0);
      chk("illegal_reject", 32'(coin_reject), 32'd1);
      step(0, 1, 3, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("change13", 32'(change_amt), 32'd13);
      step(0, 0, 0, 0, 1, 0);

      // Coin coincident with selection is rejected; price uses prior credit
      step(5, 0, 0, 0, 0, 0);
      step(5, 1, 1, 0, 0, 0);
      chk("coincident_reject", 32'(coin_reject), 32'd1);
      chk("coincident_amt", 32'(change_amt), 32'd1);
      step(0, 0, 0, 0, 0, 0);
      chk("in_change", 32'(change_valid), 32'd1);

      // Reset while change is pending
      step(0, 0, 0, 0, 0, 1);
      chk("reset_mid_change", 32'(change_valid), 32'd0);
      step(0, 0, 0, 0, 0, 0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         c   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
         sv  = ($urandom_range(0, 5) == 0) ? 1 : 0;
         cn  = ($urandom_range(0, 11) == 0) ? 1 : 0;
         rdy = ($urandom_range(0, 2) == 0) ? 1 : 0;
         rst = ($urandom_range(0, 79) == 0) ? 1 : 0;
         step(c, sv, int'($urandom_range(0, 3)), cn, rdy, rst);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
